// File: rtl/iomem_timer.sv
// Memory-mapped down-counting timer for the picosoc iomem bus: 16-bit prescaler,
// COUNT_W-bit auto-reload counter, sticky expiry flag and registered level irq.
module iomem_timer #(
   parameter logic [7:0] ADDR_PREFIX = 8'h04,
   parameter int         COUNT_W     = 32
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        iomem_valid,
   output logic        iomem_ready,
   input  logic [3:0]  iomem_wstrb,
   input  logic [31:0] iomem_addr,
   input  logic [31:0] iomem_wdata,
   output logic [31:0] iomem_rdata,
   output logic        irq
);

   localparam logic [7:0] OFF_CTRL     = 8'h00;
   localparam logic [7:0] OFF_PRESCALE = 8'h04;
   localparam logic [7:0] OFF_RELOAD   = 8'h08;
   localparam logic [7:0] OFF_COUNT    = 8'h0C;
   localparam logic [7:0] OFF_STATUS   = 8'h10;

   logic               en, auto_rl, ie, flag;
   logic [15:0]        prescale, pcnt;
   logic [COUNT_W-1:0] reload, count;

   logic        sel, we, tick, count_wr, status_clr, expire;
   logic [7:0]  offset;
   logic [31:0] rd_mux, wr_mask, wr_val, count_ext, reload_ext;

   // The window only decodes the top byte; the middle bits alias the map.
   logic unused_addr;
   assign unused_addr = ^iomem_addr[23:8];

   // NOTE: every signal written in always_comb gets a default first, so no path
   // leaves it unassigned and no latch is inferred.
   always_comb begin
      offset     = iomem_addr[7:0];
      sel        = iomem_valid && !iomem_ready && (iomem_addr[31:24] == ADDR_PREFIX);
      we         = sel && (iomem_wstrb != 4'b0000);
      tick       = en && (pcnt == prescale);

      count_ext  = '0;
      reload_ext = '0;
      count_ext[COUNT_W-1:0]  = count;
      reload_ext[COUNT_W-1:0] = reload;

      rd_mux = '0;
      case (offset)
         OFF_CTRL:     rd_mux = {29'd0, ie, auto_rl, en};
         OFF_PRESCALE: rd_mux = {16'd0, prescale};
         OFF_RELOAD:   rd_mux = reload_ext;
         OFF_COUNT:    rd_mux = count_ext;
         OFF_STATUS:   rd_mux = {31'd0, flag};
         default:      rd_mux = '0;
      endcase

      // Byte-lane merge onto the current register contents at this offset.
      wr_mask = {{8{iomem_wstrb[3]}}, {8{iomem_wstrb[2]}},
                 {8{iomem_wstrb[1]}}, {8{iomem_wstrb[0]}}};
      wr_val  = (rd_mux & ~wr_mask) | (iomem_wdata & wr_mask);

      count_wr   = we && (offset == OFF_COUNT);
      status_clr = we && (offset == OFF_STATUS) && iomem_wstrb[0] && iomem_wdata[0];
      // A bus write to COUNT swallows a coincident tick, including its expiry.
      expire     = tick && !count_wr && (count == COUNT_W'(1));
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         iomem_ready <= 1'b0;
         iomem_rdata <= '0;
         irq         <= 1'b0;
         en          <= 1'b0;
         auto_rl     <= 1'b0;
         ie          <= 1'b0;
         prescale    <= '0;
         pcnt        <= '0;
         reload      <= '0;
         count       <= '0;
         flag        <= 1'b0;
      end else begin
         iomem_ready <= sel;
         if (sel) iomem_rdata <= rd_mux;

         if (we) begin
            case (offset)
               OFF_CTRL:     {ie, auto_rl, en} <= wr_val[2:0];
               OFF_PRESCALE: prescale <= wr_val[15:0];
               OFF_RELOAD:   reload   <= wr_val[COUNT_W-1:0];
               default:      ;
            endcase
         end

         if (!en || tick) pcnt <= '0;
         else             pcnt <= pcnt + 16'd1;

         // Expiry reloads from the pre-edge RELOAD, so a same-cycle write lands later.
         if (count_wr)                           count <= wr_val[COUNT_W-1:0];
         else if (tick && count > COUNT_W'(1))   count <= count - COUNT_W'(1);
         else if (expire)                        count <= auto_rl ? reload : '0;

         // Set dominates a simultaneous write-1-to-clear.
         if (expire)          flag <= 1'b1;
         else if (status_clr) flag <= 1'b0;

         irq <= flag && ie;
      end
   end

endmodule

// File: tb/tb_iomem_timer.sv
// Scoreboard bench for iomem_timer: a time-based reference model predicts every
// read and the per-cycle ready/irq levels; directed scenarios then random traffic.
module tb_iomem_timer;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        iomem_valid = 1'b0;
   logic        iomem_ready;
   logic [3:0]  iomem_wstrb = 4'd0;
   logic [31:0] iomem_addr = 32'd0;
   logic [31:0] iomem_wdata = 32'd0;
   logic [31:0] iomem_rdata;
   logic        irq;

   int vectors = 0;
   int miscompares = 0;
   logic [31:0] exp_q[$];

   iomem_timer #(.ADDR_PREFIX(8'h04), .COUNT_W(32)) dut (
      .clk(clk), .resetn(resetn), .iomem_valid(iomem_valid), .iomem_ready(iomem_ready),
      .iomem_wstrb(iomem_wstrb), .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata),
      .iomem_rdata(iomem_rdata), .irq(irq));

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: registers as plain values, ticks derived from the time
   // elapsed since EN rose (every PRESCALE+1 cycles, the last cycle of each period).
   logic [2:0]  m_ctrl = 3'd0;
   logic [15:0] m_pre = 16'd0;
   logic [31:0] m_reload = 32'd0, m_count = 32'd0;
   logic        m_flag = 1'b0, m_irq = 1'b0, m_ready = 1'b0;
   int          m_elapsed = 0;

   function automatic logic [31:0] model_read(input logic [7:0] off);
      case (off)
         8'h00:   return {29'd0, m_ctrl};
         8'h04:   return {16'd0, m_pre};
         8'h08:   return m_reload;
         8'h0C:   return m_count;
         8'h10:   return {31'd0, m_flag};
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic [31:0] lane_merge(input logic [31:0] old, input logic [31:0] data,
                                              input logic [3:0] strb);
      logic [31:0] r = old;
      for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = data[8*b +: 8];
      return r;
   endfunction

   always @(posedge clk) begin : model
      logic       sel_m, tick_m, cwr, clr, expired;
      logic [7:0] off;
      logic [31:0] wv;
      if (!resetn) begin
         m_ctrl = 3'd0; m_pre = 16'd0; m_reload = 32'd0; m_count = 32'd0;
         m_flag = 1'b0; m_irq = 1'b0; m_ready = 1'b0; m_elapsed = 0;
      end else begin
         off     = iomem_addr[7:0];
         sel_m   = iomem_valid && !m_ready && (iomem_addr[31:24] == 8'h04);
         tick_m  = m_ctrl[0] && ((m_elapsed % (int'(m_pre) + 1)) == int'(m_pre));
         wv      = lane_merge(model_read(off), iomem_wdata, iomem_wstrb);
         cwr     = sel_m && (iomem_wstrb != 4'd0) && (off == 8'h0C);
         clr     = sel_m && iomem_wstrb[0] && iomem_wdata[0] && (off == 8'h10);
         expired = tick_m && !cwr && (m_count == 32'd1);
         if (sel_m) exp_q.push_back(model_read(off));
         m_irq = m_flag && m_ctrl[2];
         if (expired) m_flag = 1'b1;
         else if (clr) m_flag = 1'b0;
         if (cwr) m_count = wv;
         else if (expired) m_count = m_ctrl[1] ? m_reload : 32'd0;
         else if (tick_m && m_count > 32'd1) m_count = m_count - 32'd1;
         m_elapsed = m_ctrl[0] ? m_elapsed + 1 : 0;
         if (sel_m && iomem_wstrb != 4'd0) begin
            case (off)
               8'h00:   m_ctrl = wv[2:0];
               8'h04:   m_pre = wv[15:0];
               8'h08:   m_reload = wv;
               default: ;
            endcase
         end
         m_ready = sel_m;
      end
   end

   // Monitor: per-cycle handshake/irq levels, and read data popped on each ready.
   always @(negedge clk) begin
      check("ready_level", {31'd0, iomem_ready}, {31'd0, m_ready});
      check("irq_level", {31'd0, irq}, {31'd0, m_irq});
      if (iomem_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL rdata_unexpected: ready with rdata 0x%08h but nothing expected", iomem_rdata);
         end else begin
            check("rdata", iomem_rdata, exp_q.pop_front());
         end
      end
   end

   // One bus access, started and finished on a falling edge.
   task automatic bus(input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] data,
                      output logic [31:0] rd);
      bit got = 0;
      iomem_valid = 1'b1; iomem_addr = addr; iomem_wstrb = strb; iomem_wdata = data;
      for (int i = 0; i < 8 && !got; i++) begin
         @(negedge clk);
         if (iomem_ready) got = 1;
      end
      rd = iomem_rdata;
      iomem_valid = 1'b0; iomem_wstrb = 4'd0;
      if (!got) check("bus_timeout", 32'd0, 32'd1);
   endtask

   task automatic wr(input logic [7:0] off, input logic [31:0] data);
      logic [31:0] r;
      bus({8'h04, 16'h0000, off}, 4'hF, data, r);
   endtask

   task automatic rd_chk(input string name, input logic [31:0] addr, input logic [31:0] exp);
      logic [31:0] r;
      bus(addr, 4'd0, 32'd0, r);
      check(name, r, exp);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      logic [31:0] r;
      int n;

      // Reset held with a pending request at the block's window.
      iomem_valid = 1'b1; iomem_addr = 32'h0400_0000;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("reset_ready", {31'd0, iomem_ready}, 32'd0);
         check("reset_irq", {31'd0, irq}, 32'd0);
      end
      iomem_valid = 1'b0;
      resetn = 1'b1;
      idle(1);
      for (int o = 0; o <= 16; o += 4) rd_chk("reset_reg", {24'h040000, 8'(o)}, 32'd0);

      // Byte lanes; read back through an aliased address.
      bus(32'h0400_0008, 4'b0101, 32'hAABB_CCDD, r);
      rd_chk("lane_reload", 32'h0412_3408, 32'h00BB_00DD);

      // Foreign window is never acknowledged.
      iomem_valid = 1'b1; iomem_addr = 32'h0300_0000;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("foreign_noready", {31'd0, iomem_ready}, 32'd0);
      end
      iomem_valid = 1'b0;

      // One-shot: 5 ticks of 4 cycles; irq follows FLAG by a cycle.
      wr(8'h04, 32'd3);
      wr(8'h0C, 32'd5);
      wr(8'h00, 32'h5);
      n = 0;
      for (int i = 1; i <= 100 && n == 0; i++) begin
         @(negedge clk);
         if (irq) n = i;
      end
      check("oneshot_irq_latency", n, 32'd21);
      rd_chk("oneshot_status", 32'h0400_0010, 32'd1);
      rd_chk("oneshot_count0", 32'h0400_000C, 32'd0);
      idle(10);
      rd_chk("oneshot_count_hold", 32'h0400_000C, 32'd0);
      wr(8'h10, 32'd1);
      check("clear_irq_lag", {31'd0, irq}, 32'd1);
      @(negedge clk);
      check("clear_irq_drop", {31'd0, irq}, 32'd0);

      // Auto-reload every cycle; clears at both phases, one lands on an expiry.
      wr(8'h00, 32'h0);
      wr(8'h04, 32'd0);
      wr(8'h08, 32'd2);
      wr(8'h0C, 32'd2);
      wr(8'h00, 32'h3);
      for (int i = 0; i < 4; i++) bus(32'h0400_000C, 4'd0, 32'd0, r);
      wr(8'h10, 32'd1);
      bus(32'h0400_0010, 4'd0, 32'd0, r);
      idle(1);
      wr(8'h10, 32'd1);
      bus(32'h0400_0010, 4'd0, 32'd0, r);

      // Pause freezes COUNT; resume continues from it.
      wr(8'h00, 32'h0);
      wr(8'h0C, 32'd7);
      idle(50);
      rd_chk("pause_count", 32'h0400_000C, 32'd7);
      wr(8'h04, 32'd2);
      wr(8'h00, 32'h1);
      idle(5);
      bus(32'h0400_000C, 4'd0, 32'd0, r);

      // COUNT write collides with a tick (tick every cycle), then two more ticks.
      wr(8'h00, 32'h0);
      wr(8'h04, 32'd0);
      wr(8'h0C, 32'd50);
      wr(8'h00, 32'h1);
      wr(8'h0C, 32'h100);
      wr(8'h00, 32'h0);
      rd_chk("collide_count", 32'h0400_000C, 32'h0000_00FE);

      // Reset mid-count with irq high and a request in flight.
      wr(8'h0C, 32'd1);
      wr(8'h00, 32'h5);
      wr(8'h00, 32'h4);
      wr(8'h0C, 32'd3);
      check("pre_reset_irq", {31'd0, irq}, 32'd1);
      iomem_valid = 1'b1; iomem_addr = 32'h0400_000C; iomem_wstrb = 4'd0;
      resetn = 1'b0;
      @(negedge clk);
      check("midreset_ready", {31'd0, iomem_ready}, 32'd0);
      check("midreset_irq", {31'd0, irq}, 32'd0);
      iomem_valid = 1'b0;
      resetn = 1'b1;
      idle(1);
      rd_chk("midreset_count", 32'h0400_000C, 32'd0);
      rd_chk("midreset_ctrl", 32'h0400_0000, 32'd0);

      // Random traffic; PRESCALE only changes while the prescaler is stopped.
      for (int k = 0; k < 400; k++) begin
         logic [7:0]  off;
         logic [3:0]  strb;
         logic [31:0] data;
         case ($urandom_range(0, 6))
            0: off = 8'h00;
            1: off = 8'h04;
            2: off = 8'h08;
            3, 6: off = 8'h0C;
            4: off = 8'h10;
            default: off = 8'($urandom);
         endcase
         strb = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom);
         data = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 12));
         if (off == 8'h04 && strb != 4'd0) begin
            if (m_ctrl[0]) strb = 4'd0;
            else data = 32'($urandom_range(0, 4));
         end
         if ($urandom_range(0, 9) == 0) begin
            iomem_valid = 1'b1; iomem_addr = {8'h05, 16'($urandom), off};
            idle(2);
            iomem_valid = 1'b0;
         end
         bus({8'h04, 16'($urandom), off}, strb, data, r);
         idle($urandom_range(0, 3));
      end

      idle(2);
      check("scoreboard_drain", exp_q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
